// File: rtl/hud_number_renderer.sv
// hud_number_renderer: per-frame binary-to-BCD conversion of a HUD value and 3x5 font rendering of five digits.
// Latency: conversion 15 cycles from an accepted frame_start; pixel colour registered, 1 cycle after request.
// Backpressure: none; frame_start while busy is dropped, pixel requests are answered every cycle.
//
// Ports:
//   clk, resetN              clock, asynchronous active-low reset
//   frame_start, value       one-cycle frame pulse and the 14-bit value sampled on it
//   requested_x/requested_y  pixel being drawn by the VGA timing chain
//   output_color             registered pixel colour (MASK_VALUE = transparent)
//   busy                     conversion in progress
//   shown_bcd                digits currently on screen, [19:16] = ten-thousands
module hud_number_renderer #(
    parameter logic [10:0] X0         = 11'd549,
    parameter logic [10:0] Y0         = 11'd85,
    parameter int          SCALE      = 4,
    parameter logic [7:0]  FG_COLOR   = 8'hff,
    parameter logic [7:0]  MASK_VALUE = 8'h62,
    parameter bit          LEAD_BLANK = 1'b1
) (
    input  logic        clk,
    input  logic        resetN,
    input  logic        frame_start,
    input  logic [13:0] value,
    input  logic [0:10] requested_x,
    input  logic [0:10] requested_y,
    output logic [7:0]  output_color,
    output logic        busy,
    output logic [19:0] shown_bcd
);

    localparam int          SHIFT    = $clog2(SCALE);
    localparam logic [11:0] REGION_W = 12'(20 * SCALE);
    localparam logic [11:0] REGION_H = 12'(5 * SCALE);

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_CONVERT = 2'd1,
        S_COMMIT  = 2'd2
    } state_t;

    state_t      r_state;
    logic [13:0] r_bin;
    logic [19:0] r_bcd;
    logic [3:0]  r_step;
    logic        r_busy;
    logic [19:0] r_shown;
    logic [7:0]  r_color;

    // ------------------------------------------------------------------
    // Double-dabble engine
    // ------------------------------------------------------------------
    logic [19:0] w_bcd_adj;

    // Correct every nibble >= 5 before the shift so it carries as decimal.
    always_comb begin
        w_bcd_adj = r_bcd;
        for (int k = 0; k < 5; k++) begin
            if (r_bcd[4*k +: 4] >= 4'd5) begin
                w_bcd_adj[4*k +: 4] = r_bcd[4*k +: 4] + 4'd3;
            end
        end
    end

    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            r_state <= S_IDLE;
            r_bin   <= '0;
            r_bcd   <= '0;
            r_step  <= '0;
            r_busy  <= 1'b0;
            r_shown <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (frame_start) begin
                        r_bin   <= value;
                        r_bcd   <= '0;
                        r_step  <= '0;
                        r_busy  <= 1'b1;
                        r_state <= S_CONVERT;
                    end
                end
                S_CONVERT: begin
                    {r_bcd, r_bin} <= {w_bcd_adj, r_bin} << 1;
                    r_step         <= r_step + 4'd1;
                    if (r_step == 4'd13) begin
                        r_state <= S_COMMIT;
                    end
                end
                S_COMMIT: begin
                    // Single-cycle publish: the display only ever sees complete results.
                    r_shown <= r_bcd;
                    r_busy  <= 1'b0;
                    r_state <= S_IDLE;
                end
                default: begin
                    r_state <= S_IDLE;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Pixel lookup
    // ------------------------------------------------------------------
    function automatic logic [2:0] font_row(input logic [3:0] digit, input logic [2:0] row);
        logic [14:0] glyph;
        logic [2:0]  bits;
        // Five rows of three bits, top row in the most significant triplet.
        case (digit)
            4'd0:    glyph = 15'o75557;
            4'd1:    glyph = 15'o26227;
            4'd2:    glyph = 15'o71747;
            4'd3:    glyph = 15'o71717;
            4'd4:    glyph = 15'o55711;
            4'd5:    glyph = 15'o74717;
            4'd6:    glyph = 15'o74757;
            4'd7:    glyph = 15'o71111;
            4'd8:    glyph = 15'o75757;
            4'd9:    glyph = 15'o75717;
            default: glyph = 15'o00000;   // codes 10..15 render blank
        endcase
        case (row)
            3'd0:    bits = glyph[14:12];
            3'd1:    bits = glyph[11:9];
            3'd2:    bits = glyph[8:6];
            3'd3:    bits = glyph[5:3];
            3'd4:    bits = glyph[2:0];
            default: bits = 3'b000;
        endcase
        return bits;
    endfunction

    logic [11:0] w_x12;
    logic [11:0] w_y12;
    logic        w_in_region;
    logic [10:0] w_rx;
    logic [10:0] w_ry;
    logic [2:0]  w_digit;
    logic [1:0]  w_col;
    logic [2:0]  w_row;
    logic [3:0]  w_nibble;
    logic [4:0]  w_lead_zero;
    logic        w_blank;
    logic [2:0]  w_row_bits;
    logic        w_lit;

    // 12-bit compares so X0 + width cannot wrap.
    assign w_x12       = {1'b0, requested_x};
    assign w_y12       = {1'b0, requested_y};
    assign w_in_region = (w_x12 >= {1'b0, X0}) && (w_x12 < ({1'b0, X0} + REGION_W)) &&
                         (w_y12 >= {1'b0, Y0}) && (w_y12 < ({1'b0, Y0} + REGION_H));

    assign w_rx    = requested_x - X0;
    assign w_ry    = requested_y - Y0;
    assign w_digit = 3'(w_rx >> (SHIFT + 2));
    assign w_col   = 2'(w_rx >> SHIFT);
    assign w_row   = 3'(w_ry >> SHIFT);

    always_comb begin
        case (w_digit)
            3'd0:    w_nibble = r_shown[19:16];
            3'd1:    w_nibble = r_shown[15:12];
            3'd2:    w_nibble = r_shown[11:8];
            3'd3:    w_nibble = r_shown[7:4];
            3'd4:    w_nibble = r_shown[3:0];
            default: w_nibble = 4'hf;
        endcase
    end

    // w_lead_zero[k]: digits 0..k (counted from the left) are all zero.
    always_comb begin
        w_lead_zero[0] = (r_shown[19:16] == 4'd0);
        for (int k = 1; k < 5; k++) begin
            w_lead_zero[k] = w_lead_zero[k-1] && (r_shown[19 - 4*k -: 4] == 4'd0);
        end
    end

    assign w_blank    = LEAD_BLANK && (w_digit < 3'd4) && w_lead_zero[w_digit];
    assign w_row_bits = font_row(w_nibble, w_row);

    always_comb begin
        case (w_col)
            2'd0:    w_lit = w_row_bits[2];
            2'd1:    w_lit = w_row_bits[1];
            2'd2:    w_lit = w_row_bits[0];
            default: w_lit = 1'b0;   // spacer column
        endcase
    end

    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            r_color <= MASK_VALUE;
        end else if (w_in_region && !w_blank && w_lit) begin
            r_color <= FG_COLOR;
        end else begin
            r_color <= MASK_VALUE;
        end
    end

    assign output_color = r_color;
    assign busy         = r_busy;
    assign shown_bcd    = r_shown;

endmodule

// File: tb/tb_hud_number_renderer.sv
module tb_hud_number_renderer;

    localparam int X0 = 549;
    localparam int Y0 = 85;
    localparam logic [7:0] FG   = 8'hff;
    localparam logic [7:0] MASK = 8'h62;

    logic        clk = 1'b0;
    logic        resetN;
    logic        frame_start;
    logic [13:0] value;
    logic [0:10] requested_x;
    logic [0:10] requested_y;
    logic [7:0]  output_color;
    logic        busy;
    logic [19:0] shown_bcd;

    int vectors    = 0;
    int miscompares = 0;
    int exp_val    = 0;   // value the display should currently show

    int font [10][5] = '{
        '{7,5,5,5,7}, '{2,6,2,2,7}, '{7,1,7,4,7}, '{7,1,7,1,7}, '{5,5,7,1,1},
        '{7,4,7,1,7}, '{7,4,7,5,7}, '{7,1,1,1,1}, '{7,5,7,5,7}, '{7,5,7,1,7}
    };

    hud_number_renderer dut (
        .clk          (clk),
        .resetN       (resetN),
        .frame_start  (frame_start),
        .value        (value),
        .requested_x  (requested_x),
        .requested_y  (requested_y),
        .output_color (output_color),
        .busy         (busy),
        .shown_bcd    (shown_bcd)
    );

    always #5 clk = ~clk;

    // ---------------- reference model ----------------
    function automatic int pow10(int e);
        int p = 1;
        for (int i = 0; i < e; i++) p = p * 10;
        return p;
    endfunction

    function automatic logic [19:0] ref_bcd(int val);
        logic [19:0] r = '0;
        for (int k = 0; k < 5; k++) r = r | (20'((val / pow10(k)) % 10) << (4 * k));
        return r;
    endfunction

    function automatic logic [7:0] ref_pix(int val, int x, int y);
        int rx, ry, d, col, row, dig;
        if (x < X0 || x >= X0 + 80 || y < Y0 || y >= Y0 + 20) return MASK;
        rx  = x - X0;
        ry  = y - Y0;
        d   = rx / 16;
        col = (rx / 4) % 4;
        row = ry / 4;
        if (col == 3) return MASK;
        // digit d and everything left of it zero <=> val below 10^(4-d)
        if (d < 4 && val < pow10(4 - d)) return MASK;
        dig = (val / pow10(4 - d)) % 10;
        return (((font[dig][row] >> (2 - col)) & 1) == 1) ? FG : MASK;
    endfunction

    // ---------------- stimulus primitives ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_frame(input int val);
        value       = 14'(val);
        frame_start = 1'b1;
        tick();
        frame_start = 1'b0;
    endtask

    task automatic set_pix(input int x, input int y);
        requested_x = 11'(x);
        requested_y = 11'(y);
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        resetN = 1'b0;
        frame_start = 1'b0;
        value = '0;
        set_pix(X0 + 64, Y0);
        tick(); tick();
        vectors++;
        if (output_color !== MASK) begin
            miscompares++;
            $display("FAIL reset_color_in_reset: got %h expected %h", output_color, MASK);
        end
        resetN = 1'b1;
        tick();
        vectors++;
        if (output_color !== 8'hff) begin
            miscompares++;
            $display("FAIL reset_units_zero_pixel: got %h expected ff", output_color);
        end
        vectors++;
        if (busy !== 1'b0) begin
            miscompares++;
            $display("FAIL reset_busy: got %b expected 0", busy);
        end
        vectors++;
        if (shown_bcd !== 20'h0) begin
            miscompares++;
            $display("FAIL reset_shown_bcd: got %h expected 00000", shown_bcd);
        end
        exp_val = 0;
    endtask

    task automatic test_conversion();
        pulse_frame(1234);
        for (int i = 0; i < 15; i++) begin
            vectors++;
            if (busy !== 1'b1) begin
                miscompares++;
                $display("FAIL conv_busy_cycle%0d: got %b expected 1", i + 1, busy);
            end
            vectors++;
            if (shown_bcd !== ref_bcd(exp_val)) begin
                miscompares++;
                $display("FAIL conv_no_partial_cycle%0d: got %h expected %h", i + 1, shown_bcd, ref_bcd(exp_val));
            end
            tick();
        end
        exp_val = 1234;
        vectors++;
        if (busy !== 1'b0) begin
            miscompares++;
            $display("FAIL conv_busy_drop: got %b expected 0", busy);
        end
        vectors++;
        if (shown_bcd !== 20'h01234) begin
            miscompares++;
            $display("FAIL conv_shown_bcd: got %h expected 01234", shown_bcd);
        end
        set_pix(X0, Y0);
        tick();
        vectors++;
        if (output_color !== 8'h62) begin
            miscompares++;
            $display("FAIL conv_lead_blank_pixel: got %h expected 62", output_color);
        end
        set_pix(X0 + 20, Y0);
        tick();
        vectors++;
        if (output_color !== 8'hff) begin
            miscompares++;
            $display("FAIL conv_one_top_mid_pixel: got %h expected ff", output_color);
        end
    endtask

    task automatic test_maximum();
        pulse_frame(16383);
        for (int i = 0; i < 15; i++) tick();
        exp_val = 16383;
        vectors++;
        if (shown_bcd !== 20'h16383) begin
            miscompares++;
            $display("FAIL max_shown_bcd: got %h expected 16383", shown_bcd);
        end
        set_pix(X0 + 12, Y0);
        tick();
        vectors++;
        if (output_color !== 8'h62) begin
            miscompares++;
            $display("FAIL max_spacer_pixel: got %h expected 62", output_color);
        end
        set_pix(X0, Y0);
        tick();
        vectors++;
        if (output_color !== ref_pix(exp_val, X0, Y0)) begin
            miscompares++;
            $display("FAIL max_first_digit_pixel: got %h expected %h", output_color, ref_pix(exp_val, X0, Y0));
        end
    endtask

    task automatic test_busy_collision();
        pulse_frame(42);               // accepted at cycle N, now in N+1
        for (int i = 0; i < 4; i++) tick();
        pulse_frame(99);               // frame_start high at N+5, must be ignored
        for (int i = 0; i < 10; i++) tick();   // cycle N+16
        exp_val = 42;
        vectors++;
        if (busy !== 1'b0) begin
            miscompares++;
            $display("FAIL collision_busy_end: got %b expected 0", busy);
        end
        vectors++;
        if (shown_bcd !== 20'h00042) begin
            miscompares++;
            $display("FAIL collision_shown_bcd: got %h expected 00042", shown_bcd);
        end
        for (int i = 0; i < 20; i++) tick();
        vectors++;
        if (busy !== 1'b0 || shown_bcd !== 20'h00042) begin
            miscompares++;
            $display("FAIL collision_not_queued: got busy=%b bcd=%h expected busy=0 bcd=00042", busy, shown_bcd);
        end
    endtask

    task automatic test_reset_mid();
        pulse_frame(500);              // now in N+1
        for (int i = 0; i < 6; i++) tick();    // cycle N+7
        resetN = 1'b0;
        #1;
        exp_val = 0;
        vectors++;
        if (shown_bcd !== 20'h0 || busy !== 1'b0) begin
            miscompares++;
            $display("FAIL midreset_abort: got busy=%b bcd=%h expected busy=0 bcd=00000", busy, shown_bcd);
        end
        tick(); tick();
        resetN = 1'b1;
        for (int i = 0; i < 20; i++) tick();
        vectors++;
        if (shown_bcd !== 20'h0 || busy !== 1'b0) begin
            miscompares++;
            $display("FAIL midreset_after_release: got busy=%b bcd=%h expected busy=0 bcd=00000", busy, shown_bcd);
        end
    endtask

    task automatic test_bounds();
        int xs [3] = '{X0 - 1, X0 + 80, X0};
        int ys [3] = '{Y0,     Y0,      Y0 + 20};
        pulse_frame(88888 % 16384);    // dense digits so in-region neighbours would be lit
        for (int i = 0; i < 15; i++) tick();
        exp_val = 88888 % 16384;
        for (int i = 0; i < 3; i++) begin
            set_pix(xs[i], ys[i]);
            tick();
            vectors++;
            if (output_color !== 8'h62) begin
                miscompares++;
                $display("FAIL bounds_%0d_(%0d,%0d): got %h expected 62", i, xs[i], ys[i], output_color);
            end
        end
    endtask

    task automatic test_random();
        int x, y, v, old_val;
        for (int n = 0; n < 8; n++) begin
            v = (n < 3) ? $urandom_range(0, 120) : $urandom_range(0, 16383);
            old_val = exp_val;
            pulse_frame(v);            // now in N+1
            // pixel path keeps serving the old digits throughout the conversion
            for (int i = 0; i < 14; i++) begin
                x = $urandom_range(X0 - 4, X0 + 84);
                y = $urandom_range(Y0 - 2, Y0 + 22);
                set_pix(x, y);
                tick();
                vectors++;
                if (output_color !== ref_pix(old_val, x, y)) begin
                    miscompares++;
                    $display("FAIL rand_busy_pix v=%0d (%0d,%0d): got %h expected %h", old_val, x, y, output_color, ref_pix(old_val, x, y));
                end
            end
            tick();                    // cycle N+16
            exp_val = v;
            vectors++;
            if (shown_bcd !== ref_bcd(v) || busy !== 1'b0) begin
                miscompares++;
                $display("FAIL rand_conv v=%0d: got busy=%b bcd=%h expected busy=0 bcd=%h", v, busy, shown_bcd, ref_bcd(v));
            end
            for (int i = 0; i < 30; i++) begin
                x = $urandom_range(X0 - 4, X0 + 84);
                y = $urandom_range(Y0 - 2, Y0 + 22);
                set_pix(x, y);
                tick();
                vectors++;
                if (output_color !== ref_pix(exp_val, x, y)) begin
                    miscompares++;
                    $display("FAIL rand_pix v=%0d (%0d,%0d): got %h expected %h", exp_val, x, y, output_color, ref_pix(exp_val, x, y));
                end
            end
        end
    endtask

    initial begin
        test_reset();
        test_conversion();
        test_maximum();
        test_busy_collision();
        test_reset_mid();
        test_bounds();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/hud_number_renderer.md
# hud_number_renderer

Consumer and display end of the score/fuel value path. Samples a 14-bit binary HUD value once per frame, converts it to five BCD digits with a sequential shift-and-add-3 (double-dabble) engine, and answers the VGA pixel requests with a registered 8-bit colour. Digits are drawn from a built-in 3x5 font. One instance is placed per displayed number (score, fuel), and its output_color feeds the same priority mixer as the other HUD object controllers.

## Interface
- X0, 11'd549: left pixel column of the number region.
- Y0, 11'd85: top pixel row of the number region.
- SCALE, 4: font pixel magnification. Must be a power of two, 1..8.
- FG_COLOR, 8'hff: colour of lit font pixels.
- MASK_VALUE, 8'h62: transparent colour.
- LEAD_BLANK, 1: 1 = suppress leading zeros. The units digit is always drawn.
- clk  in  1  system clock.
- resetN  in  1  reset. Asynchronous, active-low.
- frame_start  in  1  one-cycle pulse at the start of each frame.
- value  in  14  unsigned binary value to display (0..16383).
- requested_x  in  [0:10]  pixel column being drawn.
- requested_y  in  [0:10]  pixel row being drawn.
- output_color  out  8  registered pixel colour, or MASK_VALUE.
- busy  out  1  high while a conversion is in progress.
- shown_bcd  out  20  BCD digits currently displayed. [19:16] is the ten-thousands digit.

## Operation
- FSM states:
  - IDLE: waits for frame_start.
  - CONVERT: 14 shift steps.
  - COMMIT: one cycle, then returns to IDLE.
- IDLE, frame_start=1:
  - capture value into the shift register.
  - clear the 20-bit BCD working register.
  - step counter = 0.
  - go to CONVERT.
- CONVERT, each cycle:
  - add 3 to every working BCD nibble that is >= 5.
  - then shift {bcd, bin} left by 1.
  - step counter +1.
  - after step 13, go to COMMIT.
- COMMIT:
  - copy the working BCD register to shown_bcd as a single atomic update.
  - go to IDLE.
  - The display never shows a partially converted value.
- frame_start while busy is ignored. The in-flight conversion completes unchanged and no request is queued.
- value changing after capture has no effect until the next accepted frame_start.
- Region geometry:
  - width = 5 * 4 * SCALE pixels; height = 5 * SCALE pixels.
  - Each digit cell is 4 font columns wide: 3 glyph columns plus 1 spacer column.
- Pixel lookup for requested coordinates inside the region, with rx = requested_x - X0 and ry = requested_y - Y0 (unsigned, 11-bit):
  - digit index = rx / (4*SCALE); 0 is the leftmost (ten-thousands) digit.
  - font column = (rx / SCALE) % 4. Column 3 is the spacer and gives MASK_VALUE.
  - font row = ry / SCALE.
  - Divisions by SCALE are shifts. Division by 4*SCALE is also a shift.
- Pixel colour: FG_COLOR if the glyph bit is 1; otherwise MASK_VALUE.
- Requests outside the region give MASK_VALUE. Comparisons use requested_x >= X0 and requested_x < X0 + width, and the same form for y.
- Leading blank: with LEAD_BLANK=1, digit k is blanked (MASK_VALUE) if digits 0..k are all zero and k < 4.
- Font: row values in octal, top row first, MSB = left column.
  - 0: 7,5,5,5,7
  - 1: 2,6,2,2,7
  - 2: 7,1,7,4,7
  - 3: 7,1,7,1,7
  - 4: 5,5,7,1,1
  - 5: 7,4,7,1,7
  - 6: 7,4,7,5,7
  - 7: 7,1,1,1,1
  - 8: 7,5,7,5,7
  - 9: 7,5,7,1,7
- Nibble codes 10..15 cannot occur. If they do, the digit renders as blank.

## Timing
- Reset values: output_color = MASK_VALUE, busy = 0, shown_bcd = 0, FSM = IDLE. All internal registers cleared.
- Conversion latency:
  - frame_start sampled high in IDLE at cycle N.
  - busy = 1 for cycles N+1..N+15.
  - shown_bcd updates at the clock edge ending cycle N+15.
  - busy = 0 from cycle N+16.
  - The next frame_start is accepted at cycle N+16 at the earliest.
- Pixel latency: exactly 1 cycle. output_color at cycle t+1 reflects requested_x/y at cycle t and the shown_bcd value registered at t.
- Pixel lookup runs every cycle, independent of the FSM state.
- resetN asserted mid-conversion aborts the conversion immediately (asynchronous). shown_bcd returns to 0.

## Test plan
- Reset: hold resetN=0, then release; request (X0+4*4*SCALE, Y0) = (613, 85).
  - Required: output_color = 8'hff ('0' units digit, top-left bit set), busy = 0, shown_bcd = 0.
- Conversion: value=1234, pulse frame_start.
  - Required: busy high for 15 cycles, then shown_bcd = 20'h01234.
  - Required: pixel (X0+0, Y0) = 8'h62 (leading zero blanked).
  - Required: pixel (X0+16+4, Y0) = 8'hff (top row of '1', middle column).
- Maximum: value=16383.
  - Required: shown_bcd = 20'h16383.
  - Required: spacer pixel (X0+12, Y0) = 8'h62.
- Busy collision: pulse frame_start with value=42, then pulse frame_start again 5 cycles later with value=99.
  - Required: shown_bcd = 20'h00042; the second request is dropped.
- Reset mid-conversion: value=500, assert resetN=0 at cycle N+7.
  - Required: shown_bcd = 0, busy = 0.
  - After release with no further frame_start: shown_bcd still 0.
- Region bounds: requests at (X0-1, Y0), (X0+80, Y0), and (X0, Y0+20).
  - Required: 8'h62 for all three, regardless of the value displayed.
